pipe_ctrl: RTL and testbench

Central pipeline sequencing block for the five-stage LoongArch core. Takes hazard and redirect requests from the ID and EX stages and produces every stage-register write enable and flush. Owns the state machine and iteration counter that sequence the multi-cycle iterative divider in EX. Replaces the ad-hoc stall/flush glue in the top level with one arbitrated, priority-ordered controller.

---
 rtl/pipe_ctrl_pkg.sv | 30 +++
 rtl/pipe_ctrl_div_seq.sv | 80 ++++++++
 rtl/pipe_ctrl.sv | 79 +++++++
 tb/tb_pipe_ctrl.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline controller: divider FSM
// states, the default iteration count and the stage-control bundle.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } div_state_t;

    // 32 quotient steps plus one sign fixup.
    localparam int DIV_CYCLES_DEF = 33;

    // Stage controls, MSB first: write enables PC..MEM/WB, then flushes IF/ID..EX/MEM.
    typedef struct packed {
        logic pcwr;
        logic if_id_wr;
        logic id_ex_wr;
        logic ex_mem_wr;
        logic mem_wb_wr;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_flush;
    } stage_ctl_t;

    localparam stage_ctl_t CTL_RESET     = stage_ctl_t'(8'b00000_111);
    localparam stage_ctl_t CTL_RUN       = stage_ctl_t'(8'b11111_000);
    localparam stage_ctl_t CTL_FLUSH_ALL = stage_ctl_t'(8'b11111_111);

endpackage

// File: rtl/pipe_ctrl_div_seq.sv
// Divider sequencer: IDLE/RUN/DONE state machine plus iteration counter
// that paces the iterative divider in EX and raises the EX stall.
module div_seq
    import pipe_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = DIV_CYCLES_DEF,
    parameter int CNT_W      = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic div_req,
    input  logic br_taken,
    input  logic ws_flush,
    output logic div_start,
    output logic div_step,
    output logic div_done,
    output logic div_busy,
    output logic div_stall
);

    div_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // NOTE: each comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (ws_flush) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (div_req && !br_taken) begin
                        state_nxt = S_RUN;
                        cnt_nxt   = CNT_W'(DIV_CYCLES - 1);
                    end
                end
                S_RUN: begin
                    if (cnt == '0) state_nxt = S_DONE;
                    else           cnt_nxt   = cnt - CNT_W'(1);
                end
                S_DONE:  state_nxt = S_IDLE;
                default: begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // An aborting ws_flush suppresses step/done for the squashed instruction.
    always_comb begin
        div_start = 1'b0;
        div_step  = 1'b0;
        div_done  = 1'b0;
        if (!reset) begin
            case (state)
                S_IDLE:  div_start = div_req && !br_taken && !ws_flush;
                S_RUN:   div_step  = !ws_flush;
                S_DONE:  div_done  = !ws_flush;
                default: ;
            endcase
        end
        div_busy  = !reset && (state != S_IDLE);
        div_stall = !reset && ((div_req && state != S_DONE) || state == S_RUN);
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: priority-encodes flush/redirect/stall
// requests into stage-register write enables and bubble flushes.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = DIV_CYCLES_DEF,
    parameter int CNT_W      = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic load_stall,
    input  logic div_req,
    input  logic br_taken,
    input  logic ws_flush,
    output logic pcwr,
    output logic IF_IDwr,
    output logic ID_EXwr,
    output logic EX_MEMwr,
    output logic MEM_WBwr,
    output logic IF_IDflush,
    output logic ID_EXflush,
    output logic EX_MEMflush,
    output logic div_start,
    output logic div_step,
    output logic div_done,
    output logic div_busy
);

    logic       div_stall;
    stage_ctl_t ctl;

    div_seq #(
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_W      (CNT_W)
    ) u_div_seq (
        .clk       (clk),
        .reset     (reset),
        .div_req   (div_req),
        .br_taken  (br_taken),
        .ws_flush  (ws_flush),
        .div_start (div_start),
        .div_step  (div_step),
        .div_done  (div_done),
        .div_busy  (div_busy),
        .div_stall (div_stall)
    );

    always_comb begin
        ctl = CTL_RUN;
        if (reset) begin
            ctl = CTL_RESET;
        end else if (ws_flush) begin
            ctl = CTL_FLUSH_ALL;
        end else if (br_taken) begin
            ctl.if_id_flush = 1'b1;
            ctl.id_ex_flush = 1'b1;
        end else if (div_stall) begin
            // ID/EX is held, never flushed, so the divide operands survive a load-use hit.
            ctl.pcwr         = 1'b0;
            ctl.if_id_wr     = 1'b0;
            ctl.id_ex_wr     = 1'b0;
            ctl.ex_mem_flush = 1'b1;
        end else if (load_stall) begin
            ctl.pcwr        = 1'b0;
            ctl.if_id_wr    = 1'b0;
            ctl.id_ex_flush = 1'b1;
        end
    end

    assign pcwr        = ctl.pcwr;
    assign IF_IDwr     = ctl.if_id_wr;
    assign ID_EXwr     = ctl.id_ex_wr;
    assign EX_MEMwr    = ctl.ex_mem_wr;
    assign MEM_WBwr    = ctl.mem_wb_wr;
    assign IF_IDflush  = ctl.if_id_flush;
    assign ID_EXflush  = ctl.id_ex_flush;
    assign EX_MEMflush = ctl.ex_mem_flush;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: table of single-cycle vectors plus
// hand-written divide, abort and reset sequences, checked through a queue.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int DIVC = 33;

    // Output vector: {pcwr,IF_IDwr,ID_EXwr,EX_MEMwr,MEM_WBwr, IF_IDflush,ID_EXflush,EX_MEMflush, start,step,done,busy}
    localparam logic [11:0] E_NORMAL = 12'b11111_000_0000;
    localparam logic [11:0] E_RESET  = 12'b00000_111_0000;
    localparam logic [11:0] E_LOAD   = 12'b00111_010_0000;
    localparam logic [11:0] E_BR     = 12'b11111_110_0000;
    localparam logic [11:0] E_WS     = 12'b11111_111_0000;
    localparam logic [11:0] E_START  = 12'b00011_001_1000;
    localparam logic [11:0] E_RUN    = 12'b00011_001_0101;
    localparam logic [11:0] E_DONE   = 12'b11111_000_0011;
    localparam logic [11:0] E_WS_RUN = 12'b11111_111_0001;

    logic clk = 1'b0;
    logic reset, load_stall, div_req, br_taken, ws_flush;
    logic pcwr, IF_IDwr, ID_EXwr, EX_MEMwr, MEM_WBwr;
    logic IF_IDflush, ID_EXflush, EX_MEMflush;
    logic div_start, div_step, div_done, div_busy;
    logic [11:0] act;

    int n_checks = 0;
    int n_pass   = 0;

    logic [11:0] sb_q[$];
    string       name_q[$];

    always #5 clk = ~clk;

    pipe_ctrl #(.DIV_CYCLES(DIVC), .CNT_W(6)) dut (
        .clk(clk), .reset(reset),
        .load_stall(load_stall), .div_req(div_req),
        .br_taken(br_taken), .ws_flush(ws_flush),
        .pcwr(pcwr), .IF_IDwr(IF_IDwr), .ID_EXwr(ID_EXwr),
        .EX_MEMwr(EX_MEMwr), .MEM_WBwr(MEM_WBwr),
        .IF_IDflush(IF_IDflush), .ID_EXflush(ID_EXflush), .EX_MEMflush(EX_MEMflush),
        .div_start(div_start), .div_step(div_step),
        .div_done(div_done), .div_busy(div_busy)
    );

    assign act = {pcwr, IF_IDwr, ID_EXwr, EX_MEMwr, MEM_WBwr,
                  IF_IDflush, ID_EXflush, EX_MEMflush,
                  div_start, div_step, div_done, div_busy};

    typedef struct {
        logic        ls, dr, bt, wf;
        logic [11:0] exp;
        string       name;
    } vec_t;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, actual, expected, $time);
    endtask

    // Drive one cycle at posedge+1, queue the expectation, compare at negedge.
    task automatic step(input logic ls, dr, bt, wf, input logic [11:0] exp, input string name);
        logic [11:0] e;
        string       n;
        load_stall = ls; div_req = dr; br_taken = bt; ws_flush = wf;
        sb_q.push_back(exp);
        name_q.push_back(name);
        @(negedge clk);
        e = sb_q.pop_front();
        n = name_q.pop_front();
        check(n, 32'(act), 32'(e));
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_state(input string name);
        check({name, "_state"}, 32'(dut.u_div_seq.state), 32'(S_IDLE));
        check({name, "_cnt"}, 32'(dut.u_div_seq.cnt), 32'd0);
    endtask

    // Full divide: start, DIVC step cycles, done. ls held through the stalled cycles.
    task automatic run_div(input logic ls, input string tag);
        step(ls, 1'b1, 1'b0, 1'b0, E_START, {tag, "_start"});
        for (int i = 0; i < DIVC; i++)
            step(ls, 1'b1, 1'b0, 1'b0, E_RUN, $sformatf("%s_run%0d", tag, i));
        step(1'b0, 1'b1, 1'b0, 1'b0, E_DONE, {tag, "_done"});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, E_NORMAL, "idle"});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, E_LOAD,   "load_stall"});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, E_NORMAL, "load_released"});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b0, E_BR,     "br_over_load"});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, E_BR,     "br_over_div"});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, E_NORMAL, "fsm_stayed_idle"});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1, E_WS,     "ws_over_all"});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, E_NORMAL, "after_ws_idle"});

        reset = 1'b1; load_stall = 1'b1; div_req = 1'b1; br_taken = 1'b0; ws_flush = 1'b0;
        @(negedge clk);
        check("reset_outputs", 32'(act), 32'(E_RESET));
        check_idle_state("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        foreach (vecs[i])
            step(vecs[i].ls, vecs[i].dr, vecs[i].bt, vecs[i].wf, vecs[i].exp, vecs[i].name);

        // Plain divide, then back-to-back divide with a load-use hazard held.
        run_div(1'b0, "div");
        run_div(1'b1, "div_ls");
        run_div(1'b0, "div_b2b");
        step(1'b0, 1'b0, 1'b0, 1'b0, E_NORMAL, "div_drained");

        // ws_flush on RUN cycle 10 aborts; no done afterwards.
        step(1'b0, 1'b1, 1'b0, 1'b0, E_START, "ws_div_start");
        for (int i = 0; i < 10; i++)
            step(1'b0, 1'b1, 1'b0, 1'b0, E_RUN, $sformatf("ws_run%0d", i));
        step(1'b0, 1'b1, 1'b0, 1'b1, E_WS_RUN, "ws_abort");
        check_idle_state("ws_abort");
        step(1'b0, 1'b0, 1'b0, 1'b0, E_NORMAL, "ws_after1");
        step(1'b0, 1'b0, 1'b0, 1'b0, E_NORMAL, "ws_after2");

        // Reset mid-RUN takes effect without waiting for a clock edge.
        step(1'b0, 1'b1, 1'b0, 1'b0, E_START, "rst_div_start");
        for (int i = 0; i < 5; i++)
            step(1'b0, 1'b1, 1'b0, 1'b0, E_RUN, $sformatf("rst_run%0d", i));
        #1;
        reset = 1'b1;
        #1;
        check("rst_async_outputs", 32'(act), 32'(E_RESET));
        check_idle_state("rst_async");
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0, E_NORMAL, "rst_after1");
        step(1'b0, 1'b0, 1'b0, 1'b0, E_NORMAL, "rst_after2");

        // A fresh divide after the aborts still runs the full length.
        run_div(1'b0, "div_post");
        step(1'b0, 1'b0, 1'b0, 1'b0, E_NORMAL, "final_idle");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
